fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter that shares the async FIFO write port (`w_en`, `data_in`, `full`) among `NUM_REQ` producers in the `wclk` domain. It grants one requester at a time in round-robin order and lets the owner stream up to `BURST` words back-to-back. It stalls on `full` and never issues a write while `full` is high. It sits between the producer blocks and the FIFO write interface. The FIFO itself and the pointer synchronisers are unchanged.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `data_width`, 8: word width; must match the FIFO.
- `BURST`, 16: maximum words per grant, ≥1.

- `wclk`  in  1  write-domain clock; all state is on its rising edge.
- `w_rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  bit i high means requester i presents a valid word.
- `req_data`  in  NUM_REQ*data_width  word of requester i in bits [i*data_width +: data_width].
- `full`  in  1  FIFO full flag, write domain.
- `ack`  out  NUM_REQ  one-hot or zero; bit i high means requester i's word is written at this edge.
- `w_en`  out  1  FIFO write enable.
- `data_in`  out  data_width  FIFO write data.
- `grant_id`  out  $clog2(NUM_REQ)  current/last owner.
- `busy`  out  1  high while in GRANT.

## Operation
- **Registered state:**
  - `state` ∈ {IDLE, GRANT}.
  - `owner`.
  - `cnt`, width $clog2(BURST+1).
  - `rr_ptr`.
- **Reset values (asynchronous, immediate):**
  - `state` = IDLE; `owner`, `cnt` and `rr_ptr` = 0.
  - Outputs: `w_en` = 0, `ack` = 0, `data_in` = 0, `grant_id` = 0, `busy` = 0.
- **IDLE:**
  - If `|req`, select the first set bit scanning from `rr_ptr` upward with wrap (for example, `rr_ptr`=3, `req`=4'b0101 selects 0).
  - On the selection, `owner` ← selected index, `cnt` ← 0, next state GRANT.
  - No write occurs in IDLE.
- **GRANT, transfer condition** `xfer = req[owner] & ~full`:
  - `w_en` = `xfer`.
  - `ack` = `xfer` << `owner`.
  - `data_in` = `req_data[owner]` when `xfer`, else 0.
- **GRANT, release conditions** (next state IDLE, `rr_ptr` ← (`owner`+1) mod NUM_REQ):
  - `xfer` and `cnt` == BURST-1 (burst exhausted).
  - `~req[owner]` and `~full` (owner has nothing to send).
- **GRANT, on `xfer` without release:** `cnt` ← `cnt`+1.
- **GRANT, while `full`:** hold the grant. `cnt`, `owner` and `rr_ptr` are unchanged, even if `req[owner]` drops. The release decision is re-evaluated once `full` falls.
- **Non-owner requests** are ignored while in GRANT and get no `ack`.
- **Status outputs:** `grant_id` = `owner`; `busy` = (`state` == GRANT).
- **Simultaneous `full` fall and `req[owner]` rise:** the write happens in that cycle.
- **Reset mid-burst:** the burst is abandoned and no `ack` is issued; after release, arbitration restarts from requester 0.

## Timing
- `w_en`, `ack` and `data_in` are combinational from registered state plus `req`, `req_data` and `full`. The FIFO and the requester both sample at the same `wclk` edge, so data moves with zero added latency once granted.
- Arbitration costs exactly 1 cycle (IDLE) per grant. Sustained throughput for one busy requester is BURST words per BURST+1 cycles.
- `full` is consumed in the same cycle it is seen. `w_en` & `full` must never both be high; a bench assertion checks this every cycle.
- `ack` must be at most one-hot every cycle, and `ack[i]` implies `req[i]`.
- The requester must hold `req_data` stable while `req` is high and `ack` is low.
- Fairness: any requester holding `req` waits at most (NUM_REQ-1)·(BURST+1) cycles for a grant, plus `full` stall cycles.

## Test plan
- **Single burst:** `req`=4'b0001 held, `full`=0, BURST=16 → IDLE 1 cycle, then 16 consecutive `w_en` with `ack`=4'b0001, then 1 IDLE cycle, then the next 16 writes; `grant_id`=0 throughout.
- **Round-robin:** `req`=4'b1111 held → grant order 0,1,2,3,0; each grant is 16 writes separated by one idle cycle; `data_in` equals the owner's word every write.
- **Full stall:** owner 1 mid-burst at `cnt`=5, `full`=1 for 3 cycles → `w_en`=0 and `ack`=0 for 3 cycles, `cnt` holds at 5; the burst resumes and totals 16 writes.
- **Early release:** owner 2 drops `req` after 3 writes with `full`=0 → next cycle IDLE, `rr_ptr`=3; a waiting requester 3 is granted on the following cycle.
- **Reset mid-burst:** assert `w_rst_n`=0 asynchronously between edges during GRANT → outputs go to zero immediately; after release with `req`=4'b1000, requester 3 is granted after 1 IDLE cycle.
- **BURST=1, NUM_REQ=2, both requesting:** alternating writes 0,1,0,1, each separated by one idle cycle, with no write while `full` is high.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the round-robin arbiter and the
// async FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*data_width-1:0] req_data;
  logic                          full;
  logic [NUM_REQ-1:0]            ack;
  logic                          w_en;
  logic [data_width-1:0]         data_in;
  logic [$clog2(NUM_REQ)-1:0]    grant_id;
  logic                          busy;

  // master: producers plus FIFO flag; slave: the arbiter itself
  modport master (output req, req_data, full,
                  input  ack, w_en, data_in, grant_id, busy);
  modport slave  (input  req, req_data, full,
                  output ack, w_en, data_in, grant_id, busy);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers;
// the owner streams up to BURST words, stalling (never writing) on full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 8,
  parameter int BURST      = 16
) (
  input logic               wclk,
  input logic               w_rst_n,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  cnt;

  logic           xfer;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] owner_inc;

  // Write strobe, ack and data are combinational so a granted word moves at
  // the very edge the FIFO samples it.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    xfer        = 1'b0;
    bus.w_en    = 1'b0;
    bus.ack     = '0;
    bus.data_in = '0;
    if (state == GRANT) begin
      xfer = bus.req[owner] & ~bus.full;
      if (xfer) begin
        bus.w_en    = 1'b1;
        bus.ack     = NUM_REQ'(1) << owner;
        bus.data_in = bus.req_data[int'(owner)*data_width +: data_width];
      end
    end
  end

  // First requester at or above rr_ptr, wrapping back to 0.
  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        sel   = IDW'((int'(rr_ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  assign owner_inc    = (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign bus.grant_id = owner;
  assign bus.busy     = (state == GRANT);

  always_ff @(posedge wclk or negedge w_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!w_rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            owner <= sel;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          // While full the grant is frozen; release is only decided once full drops.
          if (!bus.full) begin
            if ((xfer && cnt == CW'(BURST - 1)) || !bus.req[owner]) begin
              state  <= IDLE;
              rr_ptr <= owner_inc;
            end else if (xfer) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: a 4-requester/BURST=16 arbiter and a 2-requester/BURST=1
// arbiter share clock and reset; expectations are hand-derived per cycle.
module tb_fifo_wr_arbiter;
  logic wclk;
  logic w_rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] word_a [4];
  logic [7:0] word_b [2];

  fifo_wr_arbiter_if #(.NUM_REQ(4), .data_width(8)) bus_a ();
  fifo_wr_arbiter_if #(.NUM_REQ(2), .data_width(8)) bus_b ();

  fifo_wr_arbiter #(.NUM_REQ(4), .data_width(8), .BURST(16)) dut_a (
    .wclk(wclk), .w_rst_n(w_rst_n), .bus(bus_a.slave));
  fifo_wr_arbiter #(.NUM_REQ(2), .data_width(8), .BURST(1)) dut_b (
    .wclk(wclk), .w_rst_n(w_rst_n), .bus(bus_b.slave));

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Protocol invariants on both instances, sampled mid-cycle.
  always @(negedge wclk) begin
    if (w_rst_n) begin
      check("a_wen_full", 32'(bus_a.w_en & bus_a.full), 0);
      check("a_ack_onehot", 32'($onehot0(bus_a.ack)), 1);
      check("a_ack_req", 32'(bus_a.ack & ~bus_a.req), 0);
      check("b_wen_full", 32'(bus_b.w_en & bus_b.full), 0);
      check("b_ack_onehot", 32'($onehot0(bus_b.ack)), 1);
      check("b_ack_req", 32'(bus_b.ack & ~bus_b.req), 0);
    end
  end

  task automatic next_cycle();
    @(posedge wclk);
    #1;
  endtask

  task automatic drive_a();
    bus_a.req_data = {word_a[3], word_a[2], word_a[1], word_a[0]};
  endtask

  task automatic drive_b();
    bus_b.req_data = {word_b[1], word_b[0]};
  endtask

  task automatic check_idle_a();
    #1;
    check("a_idle_w_en", 32'(bus_a.w_en), 0);
    check("a_idle_ack", 32'(bus_a.ack), 0);
    check("a_idle_busy", 32'(bus_a.busy), 0);
  endtask

  task automatic check_write_a(input int o);
    #1;
    check("a_w_en", 32'(bus_a.w_en), 1);
    check("a_ack", 32'(bus_a.ack), 32'(1) << o);
    check("a_data_in", 32'(bus_a.data_in), 32'(word_a[o]));
    check("a_grant_id", 32'(bus_a.grant_id), 32'(o));
    check("a_busy", 32'(bus_a.busy), 1);
  endtask

  task automatic check_hold_a(input int o);
    #1;
    check("a_hold_w_en", 32'(bus_a.w_en), 0);
    check("a_hold_ack", 32'(bus_a.ack), 0);
    check("a_hold_data", 32'(bus_a.data_in), 0);
    check("a_hold_grant", 32'(bus_a.grant_id), 32'(o));
    check("a_hold_busy", 32'(bus_a.busy), 1);
  endtask

  task automatic write_loop_a(input int o, input int n);
    for (int k = 0; k < n; k++) begin
      check_write_a(o);
      next_cycle();
      word_a[o] = word_a[o] + 8'd1;
      drive_a();
    end
  endtask

  task automatic run_burst_a(input int o, input int n);
    check_idle_a();
    next_cycle();
    write_loop_a(o, n);
  endtask

  task automatic check_idle_b();
    #1;
    check("b_idle_w_en", 32'(bus_b.w_en), 0);
    check("b_idle_busy", 32'(bus_b.busy), 0);
  endtask

  task automatic check_write_b(input int o);
    #1;
    check("b_w_en", 32'(bus_b.w_en), 1);
    check("b_ack", 32'(bus_b.ack), 32'(1) << o);
    check("b_data_in", 32'(bus_b.data_in), 32'(word_b[o]));
    check("b_grant_id", 32'(bus_b.grant_id), 32'(o));
  endtask

  initial begin
    word_a = '{8'h00, 8'h40, 8'h80, 8'hC0};
    word_b = '{8'h11, 8'h99};
    w_rst_n = 1'b0;
    bus_a.req = '0; bus_a.full = 1'b0; drive_a();
    bus_b.req = '0; bus_b.full = 1'b0; drive_b();

    // Reset state
    next_cycle();
    #1;
    check("rst_w_en", 32'(bus_a.w_en), 0);
    check("rst_ack", 32'(bus_a.ack), 0);
    check("rst_data_in", 32'(bus_a.data_in), 0);
    check("rst_grant_id", 32'(bus_a.grant_id), 0);
    check("rst_busy", 32'(bus_a.busy), 0);
    #2 w_rst_n = 1'b1;
    next_cycle();

    // Single requester: idle, 16 writes, idle, 16 writes
    bus_a.req = 4'b0001;
    run_burst_a(0, 16);
    run_burst_a(0, 16);

    // All requesting: rr_ptr is now 1, so order 1,2,3,0,1
    bus_a.req = 4'b1111;
    run_burst_a(1, 16);
    run_burst_a(2, 16);
    run_burst_a(3, 16);
    run_burst_a(0, 16);
    run_burst_a(1, 16);

    // Full stall: owner 1 after 5 writes, full for 3 cycles with req dropping
    bus_a.req = 4'b0010;
    run_burst_a(1, 5);
    bus_a.full = 1'b1;
    check_hold_a(1);
    next_cycle();
    bus_a.req = 4'b0000;
    check_hold_a(1);
    next_cycle();
    check_hold_a(1);
    next_cycle();
    bus_a.full = 1'b0;
    bus_a.req  = 4'b0010;
    write_loop_a(1, 11);

    // Early release: owner 2 (requester 3 waiting) drops after 3 writes
    bus_a.req = 4'b1100;
    run_burst_a(2, 3);
    bus_a.req = 4'b1001;
    check_hold_a(2);
    next_cycle();
    // rr_ptr=3 picks 3 ahead of 0
    run_burst_a(3, 2);

    // Reset mid-burst
    check_write_a(3);
    #1 w_rst_n = 1'b0;
    #1;
    check("mid_rst_w_en", 32'(bus_a.w_en), 0);
    check("mid_rst_ack", 32'(bus_a.ack), 0);
    check("mid_rst_data", 32'(bus_a.data_in), 0);
    check("mid_rst_busy", 32'(bus_a.busy), 0);
    check("mid_rst_grant", 32'(bus_a.grant_id), 0);
    bus_a.req = 4'b1000;
    next_cycle();
    w_rst_n = 1'b1;
    run_burst_a(3, 16);
    bus_a.req = 4'b0000;

    // BURST=1, two requesters: alternate with an idle cycle between writes
    bus_b.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      check_idle_b();
      next_cycle();
      check_write_b(k % 2);
      next_cycle();
      word_b[k % 2] = word_b[k % 2] + 8'd1;
      drive_b();
    end
    check_idle_b();
    next_cycle();
    bus_b.full = 1'b1;
    #1;
    check("b_full_w_en", 32'(bus_b.w_en), 0);
    check("b_full_ack", 32'(bus_b.ack), 0);
    check("b_full_busy", 32'(bus_b.busy), 1);
    next_cycle();
    bus_b.full = 1'b0;
    check_write_b(0);
    next_cycle();
    bus_b.req = 2'b00;
    check_idle_b();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
